mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 3, maximum consecutive data grants while a fetch waits; range 1..15.
REQ-002 clock_me  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 if_req  in  1  fetch request; held high until if_ready is seen.
REQ-005 if_addr  in  32  fetch address (PC).
REQ-006 if_flush  in  1  PC redirect; discards any fetch currently in flight.
REQ-007 if_ready  out  1  one-cycle pulse; if_instr valid.
REQ-008 if_instr  out  32  fetched instruction, registered.
REQ-009 dm_req  in  1  data request; held high until dm_ready is seen.
REQ-010 dm_we  in  1  1 = store, 0 = load.
REQ-011 dm_addr / dm_wdata  in  32 / 32  data address and store data.
REQ-012 dm_ready  out  1  one-cycle pulse; access done, dm_rdata valid for loads.
REQ-013 dm_rdata  out  32  load data, registered.
REQ-014 mem_req, mem_we  out  1, 1  shared memory request and write enable.
REQ-015 mem_addr, mem_wdata  out  32, 32  shared memory address and write data.
REQ-016 mem_ready  in  1  memory completion; mem_rdata valid in the same cycle.
REQ-017 mem_rdata  in  32  memory read data.

Function
REQ-018 The FSM SHALL have three states: IDLE, FETCH and DATA. Exactly one memory transaction SHALL be outstanding at a time.
REQ-019 In IDLE, dm_req SHALL be granted (go to DATA) if if_req is low or starve_cnt < STARVE_MAX. Otherwise a pending if_req SHALL be granted (go to FETCH).
REQ-020 On grant, the requester's addr, wdata and we SHALL be latched. mem_req SHALL be high in every FETCH and DATA cycle and low in IDLE. mem_addr, mem_we and mem_wdata SHALL come from the latched values.
REQ-021 mem_we SHALL be 0 throughout FETCH.
REQ-022 In FETCH or DATA, mem_ready = 1 SHALL complete the transaction: capture mem_rdata, go to IDLE, and pulse the matching ready signal in the following cycle.
REQ-023 Minimum latency SHALL be 2 cycles from request sampled to ready, when mem_ready is 1 in the first FETCH/DATA cycle.
REQ-024 In IDLE, the arbiter SHALL ignore the request of any requester whose ready pulse is high in that cycle (no re-grant of a completed request).
REQ-025 starve_cnt SHALL increment on each DATA grant made while if_req is high, saturating at STARVE_MAX. It SHALL clear on each FETCH grant.
REQ-026 if_flush in FETCH SHALL set a discard flag. The transaction still completes on mem_ready, but if_ready SHALL NOT pulse and if_instr SHALL keep its old value. The flag clears on return to IDLE.
REQ-027 if_flush SHALL have no effect in IDLE or DATA. Simultaneous if_flush and mem_ready in FETCH SHALL discard.
REQ-028 mem_ready SHALL be ignored in IDLE.
REQ-029 Simultaneous if_req and dm_req SHALL follow REQ-019 in the same cycle. Neither request SHALL be lost.

Reset
REQ-030 While reset is high, the block SHALL hold: state IDLE, starve_cnt 0, discard flag 0, all outputs 0 (including if_instr, dm_rdata and mem_* outputs).
REQ-031 Reset asserted mid-transaction SHALL abort it with no ready pulse. A later mem_ready for the aborted transaction SHALL be ignored per REQ-028.

Structure
REQ-032 The state encoding (IDLE=2'd0, FETCH=2'd1, DATA=2'd2) and the 32-bit word width constant SHALL live in the shared CPU constants include.
REQ-033 The block SHALL be a single module with no sub-modules. The grant logic SHALL be combinational; state, latches and outputs SHALL be registered.

Verification
REQ-034 Fetch with mem_ready tied 1: if_req=1, if_addr=0x00000040, mem_rdata=0x8C010004 -> mem_addr=0x40 for 1 cycle, if_ready pulse 2 cycles after request, if_instr=0x8C010004.
REQ-035 Store with mem_ready delayed 3 cycles: dm_req=1, dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF -> mem_req and mem_we high for 3 cycles, then one dm_ready pulse; no if_ready pulse.
REQ-036 Starvation guard: if_req and dm_req held continuously, STARVE_MAX=3 -> grant order D,D,D,F,D,D,D,F; starve_cnt returns to 0 after each F.
REQ-037 Flush: if_flush pulsed during the 2nd cycle of a 4-cycle fetch -> no if_ready pulse, if_instr unchanged, next grant proceeds normally.
REQ-038 Reset in cycle 2 of a DATA access, then mem_ready=1 after release -> no dm_ready pulse, state IDLE, all outputs 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the instruction/data memory arbiter:
// state encoding, word width and the saturating starvation counter helper.
package mem_arbiter_pkg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } arb_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] lim);
        return (v >= lim) ? lim : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch-port, data-port and shared-memory signals around the arbiter.
// master = arbiter side, slave = CPU pipeline plus memory.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic              if_req;
    logic [WORD_W-1:0] if_addr;
    logic              if_flush;
    logic              if_ready;
    logic [WORD_W-1:0] if_instr;

    logic              dm_req;
    logic              dm_we;
    logic [WORD_W-1:0] dm_addr;
    logic [WORD_W-1:0] dm_wdata;
    logic              dm_ready;
    logic [WORD_W-1:0] dm_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [WORD_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [WORD_W-1:0] mem_rdata;

    modport master (
        input  if_req, if_addr, if_flush,
        output if_ready, if_instr,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_ready, dm_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        output if_req, if_addr, if_flush,
        input  if_ready, if_instr,
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_ready, dm_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates one shared memory port between instruction fetch and data access,
// one transaction in flight, data preferred until STARVE_MAX grants pass a waiting fetch.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 3
) (
    input  logic          clock_me,
    input  logic          reset,
    mem_arbiter_if.master bus
);

    localparam logic [CNT_W-1:0] STARVE_LIM =
        CNT_W'((STARVE_MAX < 1) ? 1 : ((STARVE_MAX > 15) ? 15 : STARVE_MAX));

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              discard_q, discard_d;
    logic              if_ready_q, if_ready_d;
    logic              dm_ready_q, dm_ready_d;
    logic [WORD_W-1:0] if_instr_q, if_instr_d;
    logic [WORD_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [WORD_W-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              dm_wins, grant_dm, grant_if;

    always_ff @(posedge clock_me or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // The winner is picked from the raw requests; if the winner is the requester
    // whose ready pulse is out this cycle, nobody is granted until it re-requests.
    always_comb begin
        dm_wins  = bus.dm_req && (!bus.if_req || (starve_cnt_q < STARVE_LIM));
        grant_dm = 1'b0;
        grant_if = 1'b0;
        if (state_q == IDLE) begin
            if (dm_wins)         grant_dm = !dm_ready_q;
            else if (bus.if_req) grant_if = !if_ready_q;
        end
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_dm)      state_d = DATA;
                else if (grant_if) state_d = FETCH;
            end
            FETCH, DATA: if (bus.mem_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        discard_d    = discard_q;
        if_ready_d   = 1'b0;
        dm_ready_d   = 1'b0;
        if_instr_d   = if_instr_q;
        dm_rdata_d   = dm_rdata_q;
        mem_req_d    = (state_d != IDLE);
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (grant_dm) begin
                    mem_we_d    = bus.dm_we;
                    mem_addr_d  = bus.dm_addr;
                    mem_wdata_d = bus.dm_wdata;
                    if (bus.if_req) starve_cnt_d = sat_inc(starve_cnt_q, STARVE_LIM);
                end else if (grant_if) begin
                    mem_we_d     = 1'b0;
                    mem_addr_d   = bus.if_addr;
                    mem_wdata_d  = '0;
                    starve_cnt_d = '0;
                end
            end
            FETCH: begin
                if (bus.mem_ready) begin
                    // A flush arriving together with completion still discards.
                    if (!(discard_q || bus.if_flush)) begin
                        if_ready_d = 1'b1;
                        if_instr_d = bus.mem_rdata;
                    end
                    discard_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                end else if (bus.if_flush) begin
                    discard_d = 1'b1;
                end
            end
            DATA: begin
                if (bus.mem_ready) begin
                    dm_ready_d = 1'b1;
                    if (!mem_we_q) dm_rdata_d = bus.mem_rdata;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                end
            end
            default: begin
                discard_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock_me or posedge reset) begin
        if (reset) begin
            starve_cnt_q <= '0;
            discard_q    <= 1'b0;
            if_ready_q   <= 1'b0;
            dm_ready_q   <= 1'b0;
            if_instr_q   <= '0;
            dm_rdata_q   <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            discard_q    <= discard_d;
            if_ready_q   <= if_ready_d;
            dm_ready_q   <= dm_ready_d;
            if_instr_q   <= if_instr_d;
            dm_rdata_q   <= dm_rdata_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign bus.if_ready  = if_ready_q;
    assign bus.if_instr  = if_instr_q;
    assign bus.dm_ready  = dm_ready_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural memory with programmable latency plus a
// scoreboard of expected fetch/data results popped on each ready pulse.
`timescale 1ns/1ps
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } dm_exp_t;

    logic clock_me = 1'b0;
    logic reset;

    mem_arbiter_if bus();

    mem_arbiter #(.STARVE_MAX(3)) dut (
        .clock_me (clock_me),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 clock_me = ~clock_me;

    int          total = 0;
    int          bad   = 0;
    int          if_pulses = 0;
    int          dm_pulses = 0;
    logic [31:0] exp_instr[$];
    dm_exp_t     exp_dm[$];
    dm_exp_t     mon_e;
    logic [31:0] last_instr_exp = 32'h0;
    logic [31:0] last_rd_exp    = 32'h0;
    logic [31:0] wr_addr = 32'h0;
    logic [31:0] wr_data = 32'h0;
    int          mem_lat = 1;
    bit          force_ready = 1'b0;
    int          resp_cnt = 0;
    logic [31:0] exp_kind[8] = '{32'd1, 32'd1, 32'd1, 32'd0, 32'd1, 32'd1, 32'd1, 32'd0};
    logic [31:0] exp_cnt[8]  = '{32'd1, 32'd2, 32'd3, 32'd0, 32'd1, 32'd2, 32'd3, 32'd0};

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h8C01_0004;
        return {a[15:0], ~a[15:0]} ^ 32'h0F0F_3C3C;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock_me);
    endtask

    task automatic wait_rdy(input bit on_if, input int budget, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            seen = on_if ? bus.if_ready : bus.dm_ready;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    // memory responder: completes after mem_lat cycles of mem_req
    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(negedge clock_me);
            #1;
            if (force_ready) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = 32'hBAD0_BAD0;
            end else if (bus.mem_req) begin
                resp_cnt++;
                if (resp_cnt >= mem_lat) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = mem_model(bus.mem_addr);
                    if (bus.mem_we) begin
                        wr_addr = bus.mem_addr;
                        wr_data = bus.mem_wdata;
                    end
                    resp_cnt = 0;
                end else begin
                    bus.mem_ready = 1'b0;
                    bus.mem_rdata = $urandom;
                end
            end else begin
                bus.mem_ready = 1'b0;
                bus.mem_rdata = $urandom;
                resp_cnt = 0;
            end
        end
    end

    // scoreboard monitor
    always @(negedge clock_me) begin
        if (!reset) begin
            if (bus.if_ready) begin
                if_pulses++;
                if (exp_instr.size() == 0) chk("if_ready_unexpected", 32'(bus.if_ready), 32'd0);
                else begin
                    last_instr_exp = exp_instr.pop_front();
                    chk("if_instr", bus.if_instr, last_instr_exp);
                end
            end
            if (bus.dm_ready) begin
                dm_pulses++;
                if (exp_dm.size() == 0) chk("dm_ready_unexpected", 32'(bus.dm_ready), 32'd0);
                else begin
                    mon_e = exp_dm.pop_front();
                    if (!mon_e.we) begin
                        last_rd_exp = mon_e.data;
                        chk("dm_rdata", bus.dm_rdata, mon_e.data);
                    end else begin
                        chk("dm_rdata_hold", bus.dm_rdata, last_rd_exp);
                        chk("wr_addr", wr_addr, mon_e.addr);
                        chk("wr_data", wr_data, mon_e.data);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          p0;
        int          ngrant;
        logic        prev_req;
        logic [31:0] keep;

        reset = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
        repeat (3) tick();

        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        chk("rst_starve", 32'(dut.starve_cnt_q), 32'd0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_if_ready", 32'(bus.if_ready), 32'd0);
        chk("rst_dm_ready", 32'(bus.dm_ready), 32'd0);
        chk("rst_if_instr", bus.if_instr, 32'd0);
        chk("rst_dm_rdata", bus.dm_rdata, 32'd0);
        reset = 1'b0;

        // fetch, memory ready in the first FETCH cycle
        mem_lat = 1;
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0040;
        exp_instr.push_back(mem_model(32'h0000_0040));
        tick();
        chk("f_mem_req", 32'(bus.mem_req), 32'd1);
        chk("f_mem_addr", bus.mem_addr, 32'h0000_0040);
        chk("f_mem_we", 32'(bus.mem_we), 32'd0);
        chk("f_ready_early", 32'(bus.if_ready), 32'd0);
        tick();
        chk("f_if_ready", 32'(bus.if_ready), 32'd1);
        chk("f_if_instr", bus.if_instr, 32'h8C01_0004);
        chk("f_mem_req_off", 32'(bus.mem_req), 32'd0);
        chk("f_mem_addr_off", bus.mem_addr, 32'd0);
        bus.if_req = 1'b0;
        tick();
        chk("f_ready_once", 32'(bus.if_ready), 32'd0);

        // store with three-cycle memory latency
        mem_lat = 3;
        p0 = if_pulses;
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h100; bus.dm_wdata = 32'hDEAD_BEEF;
        exp_dm.push_back('{1'b1, 32'h100, 32'hDEAD_BEEF});
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_mem_req", 32'(bus.mem_req), 32'd1);
            chk("st_mem_we", 32'(bus.mem_we), 32'd1);
            chk("st_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
            chk("st_ready_early", 32'(bus.dm_ready), 32'd0);
        end
        tick();
        chk("st_dm_ready", 32'(bus.dm_ready), 32'd1);
        chk("st_mem_req_off", 32'(bus.mem_req), 32'd0);
        chk("st_mem_we_off", 32'(bus.mem_we), 32'd0);
        bus.dm_req = 1'b0; bus.dm_we = 1'b0;
        tick();
        chk("st_ready_once", 32'(bus.dm_ready), 32'd0);
        chk("st_no_if_ready", 32'(if_pulses - p0), 32'd0);

        // load with two-cycle latency
        mem_lat = 2;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h1000_0100;
        exp_dm.push_back('{1'b0, 32'h1000_0100, mem_model(32'h1000_0100)});
        wait_rdy(1'b0, 10, "ld_done");
        bus.dm_req = 1'b0;
        tick();
        chk("ld_rdata_hold", bus.dm_rdata, mem_model(32'h1000_0100));
        tick();

        // both requesters held continuously: D,D,D,F,D,D,D,F
        mem_lat = 1;
        bus.if_addr = 32'h0000_0800; bus.dm_addr = 32'h1000_0800; bus.dm_we = 1'b0;
        bus.if_req = 1'b1; bus.dm_req = 1'b1;
        exp_instr.push_back(mem_model(bus.if_addr));
        exp_dm.push_back('{1'b0, bus.dm_addr, mem_model(bus.dm_addr)});
        ngrant = 0;
        prev_req = bus.mem_req;
        for (int cyc = 0; cyc < 80 && (bus.if_req || bus.dm_req); cyc++) begin
            tick();
            if (bus.mem_req && !prev_req && ngrant < 8) begin
                chk($sformatf("grant%0d_kind", ngrant), 32'(bus.mem_addr[28]), exp_kind[ngrant]);
                chk($sformatf("grant%0d_starve", ngrant), 32'(dut.starve_cnt_q), exp_cnt[ngrant]);
                ngrant++;
            end
            prev_req = bus.mem_req;
            if (bus.if_ready) begin
                if (ngrant >= 8) bus.if_req = 1'b0;
                else begin
                    bus.if_addr = bus.if_addr + 32'd4;
                    exp_instr.push_back(mem_model(bus.if_addr));
                end
            end
            if (bus.dm_ready) begin
                if (ngrant >= 8) bus.dm_req = 1'b0;
                else begin
                    bus.dm_addr = bus.dm_addr + 32'd4;
                    exp_dm.push_back('{1'b0, bus.dm_addr, mem_model(bus.dm_addr)});
                end
            end
        end
        chk("starve_grants", 32'(ngrant), 32'd8);
        chk("starve_drained", 32'(bus.if_req | bus.dm_req), 32'd0);
        repeat (2) tick();

        // flush during the second cycle of a four-cycle fetch
        mem_lat = 4;
        p0 = if_pulses;
        keep = last_instr_exp;
        bus.if_addr = 32'h200; bus.if_req = 1'b1;
        tick();
        tick();
        bus.if_flush = 1'b1; bus.if_addr = 32'h300;
        exp_instr.push_back(mem_model(32'h300));
        tick();
        bus.if_flush = 1'b0;
        chk("fl_busy", 32'(bus.mem_req), 32'd1);
        tick();
        chk("fl_busy_last", 32'(bus.mem_req), 32'd1);
        mem_lat = 1;
        tick();
        chk("fl_no_ready", 32'(bus.if_ready), 32'd0);
        chk("fl_instr_kept", bus.if_instr, keep);
        chk("fl_state_idle", 32'(dut.state_q), 32'(IDLE));
        wait_rdy(1'b1, 10, "fl_refetch");
        bus.if_req = 1'b0;
        tick();
        chk("fl_pulse_count", 32'(if_pulses - p0), 32'd1);

        // reset in the second cycle of a load, then a stray mem_ready
        mem_lat = 5;
        p0 = dm_pulses;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h1000_0400;
        tick();
        tick();
        chk("rm_in_data", 32'(dut.state_q), 32'(DATA));
        reset = 1'b1; bus.dm_req = 1'b0;
        #1;
        chk("rm_async_state", 32'(dut.state_q), 32'(IDLE));
        chk("rm_async_mem_req", 32'(bus.mem_req), 32'd0);
        tick();
        reset = 1'b0;
        force_ready = 1'b1;
        tick();
        chk("rm_no_dm_ready", 32'(bus.dm_ready), 32'd0);
        chk("rm_state", 32'(dut.state_q), 32'(IDLE));
        chk("rm_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rm_mem_addr", bus.mem_addr, 32'd0);
        chk("rm_dm_rdata", bus.dm_rdata, 32'd0);
        chk("rm_if_instr", bus.if_instr, 32'd0);
        force_ready = 1'b0;
        tick();
        chk("rm_still_idle", 32'(dut.state_q), 32'(IDLE));
        chk("rm_dm_pulses", 32'(dm_pulses - p0), 32'd0);

        chk("sb_if_empty", 32'(exp_instr.size()), 32'd0);
        chk("sb_dm_empty", 32'(exp_dm.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
